serial_divisibility_by_n_using_fsm: RTL and testbench

Serial divisibility tester for a compile-time divisor N, fed one bit per accepted cycle.
- Supports MSB-first mode (Horner: r = 2r+b) and LSB-first mode (weighted: r = r + b·2^i).
- Tracks the exact remainder for any input length.
- Frames each number with start/last, gives a per-number result pulse, and flags length overflow.
- Sits in the finite-state-machine exercise set as the generalised successor to the fixed-divisor testers.

---
 rtl/serial_div_pkg.sv | 13 +
 rtl/mod_n_reduce.sv | 18 +
 rtl/serial_divisibility_by_n_using_fsm.sv | 110 +++++++++++
 tb/tb_serial_divisibility_by_n_using_fsm.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_div_pkg.sv
// Shared types and constants for the serial divisibility tester.
package serial_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_MSB = 1'b0;
  localparam logic MODE_LSB = 1'b1;

endpackage

// File: rtl/mod_n_reduce.sv
// Single conditional subtract: maps a value below 2N into the range 0..N-1.
module mod_n_reduce #(
  parameter  int unsigned DIVISOR = 5,
  localparam int unsigned REM_W   = $clog2(DIVISOR)
) (
  input  logic [REM_W:0]   a,
  output logic [REM_W-1:0] y_c
);

  localparam int unsigned AW = REM_W + 1;
  localparam logic [AW-1:0] N_EXT = AW'(DIVISOR);

  always_comb begin
    y_c = a[REM_W-1:0];
    if (a >= N_EXT) y_c = REM_W'(a - N_EXT);
  end

endmodule

// File: rtl/serial_divisibility_by_n_using_fsm.sv
// Serial remainder-mod-N tracker with MSB-first (Horner) and LSB-first (weighted) modes,
// framed by start/last with a per-number result pulse and a sticky length overflow.
module serial_divisibility_by_n_using_fsm
  import serial_div_pkg::*;
#(
  parameter  int unsigned DIVISOR  = 5,
  parameter  int unsigned MAX_BITS = 16,
  localparam int unsigned REM_W    = $clog2(DIVISOR),
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             bit_valid,
  input  logic             new_bit,
  input  logic             last,
  output logic             busy,
  output logic             div_by_n,
  output logic [REM_W-1:0] remainder,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow,
  output logic             result_valid,
  output logic             result_div
);

  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("DIVISOR must lie in 2..255");
  end

  localparam int unsigned AW = REM_W + 1;

  state_e           state_q;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] weight_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             rv_q;
  logic             rd_q;

  logic [AW-1:0]    rem_sum;
  logic [AW-1:0]    w_dbl;
  logic [REM_W-1:0] rem_nxt;
  logic [REM_W-1:0] w_nxt;
  logic             accept;

  assign accept = (state_q == RUN) && bit_valid && !start;

  // Pre-reduction sum is below 2N in both modes, so one subtract suffices.
  always_comb begin
    rem_sum = {rem_q, new_bit};
    if (mode_q == MODE_LSB) rem_sum = AW'(rem_q) + (new_bit ? AW'(weight_q) : AW'(0));
  end

  assign w_dbl = {weight_q, 1'b0};

  mod_n_reduce #(.DIVISOR(DIVISOR)) u_rem_reduce (
    .a   (rem_sum),
    .y_c (rem_nxt)
  );

  mod_n_reduce #(.DIVISOR(DIVISOR)) u_weight_reduce (
    .a   (w_dbl),
    .y_c (w_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      weight_q <= REM_W'(1);
      mode_q   <= MODE_MSB;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (start) begin
        state_q  <= RUN;
        rem_q    <= '0;
        weight_q <= REM_W'(1);
        mode_q   <= mode;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        rd_q     <= 1'b0;
      end else if (accept) begin
        rem_q    <= rem_nxt;
        weight_q <= w_nxt;
        if (cnt_q == CNT_W'(MAX_BITS)) ovf_q <= 1'b1;
        else                           cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          state_q <= DONE;
          rv_q    <= 1'b1;
          rd_q    <= (rem_nxt == '0);
        end
      end
    end
  end

  assign busy         = (state_q == RUN);
  assign div_by_n     = (rem_q == '0);
  assign remainder    = rem_q;
  assign bit_count    = cnt_q;
  assign overflow     = ovf_q;
  assign result_valid = rv_q;
  assign result_div   = rd_q;

endmodule

// File: tb/tb_serial_divisibility_by_n_using_fsm.sv
// Bench: N=5 and N=7 instances share stimulus; a value-level model checks both every cycle.
module tb_serial_divisibility_by_n_using_fsm;

  localparam int unsigned MAXB = 16;

  logic clk;
  logic rst;
  logic start, mode, bit_valid, new_bit, last;

  logic       busy5, div5, ovf5, rv5, rd5;
  logic [2:0] rem5;
  logic [4:0] cnt5;
  logic       busy7, div7, ovf7, rv7, rd7;
  logic [2:0] rem7;
  logic [4:0] cnt7;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_divisibility_by_n_using_fsm #(.DIVISOR(5), .MAX_BITS(MAXB)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_valid(bit_valid),
    .new_bit(new_bit), .last(last), .busy(busy5), .div_by_n(div5), .remainder(rem5),
    .bit_count(cnt5), .overflow(ovf5), .result_valid(rv5), .result_div(rd5)
  );

  serial_divisibility_by_n_using_fsm #(.DIVISOR(7), .MAX_BITS(MAXB)) u_dut7 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_valid(bit_valid),
    .new_bit(new_bit), .last(last), .busy(busy7), .div_by_n(div7), .remainder(rem7),
    .bit_count(cnt7), .overflow(ovf7), .result_valid(rv7), .result_div(rd7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the number's full integer value and length; expectations derive from value % N.
  longint m_val;
  int     m_len;
  bit     m_run, m_lsb, m_rv, m_rd5, m_rd7;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val = 0; m_len = 0; m_run = 0; m_lsb = 0; m_rv = 0; m_rd5 = 0; m_rd7 = 0;
    end else begin
      m_rv = 0;
      if (start) begin
        m_run = 1; m_val = 0; m_len = 0; m_lsb = mode; m_rd5 = 0; m_rd7 = 0;
      end else if (m_run && bit_valid) begin
        if (m_lsb) m_val = m_val + (longint'(new_bit) << m_len);
        else       m_val = m_val * 2 + longint'(new_bit);
        m_len++;
        if (last) begin
          m_run = 0; m_rv = 1;
          m_rd5 = (m_val % 5) == 0;
          m_rd7 = (m_val % 7) == 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input longint exp);
    total_cnt++;
    if (act === 64'(exp)) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("rem_n5",  64'(rem5),  m_val % 5);
    chk("div_n5",  64'(div5),  longint'((m_val % 5) == 0));
    chk("rem_n7",  64'(rem7),  m_val % 7);
    chk("div_n7",  64'(div7),  longint'((m_val % 7) == 0));
    chk("busy_n5", 64'(busy5), longint'(m_run));
    chk("busy_n7", 64'(busy7), longint'(m_run));
    chk("cnt_n5",  64'(cnt5),  (m_len > int'(MAXB)) ? longint'(MAXB) : longint'(m_len));
    chk("cnt_n7",  64'(cnt7),  (m_len > int'(MAXB)) ? longint'(MAXB) : longint'(m_len));
    chk("ovf_n5",  64'(ovf5),  longint'(m_len > int'(MAXB)));
    chk("ovf_n7",  64'(ovf7),  longint'(m_len > int'(MAXB)));
    chk("rv_n5",   64'(rv5),   longint'(m_rv));
    chk("rv_n7",   64'(rv7),   longint'(m_rv));
    chk("rd_n5",   64'(rd5),   longint'(m_rd5));
    chk("rd_n7",   64'(rd7),   longint'(m_rd7));
  end

  task automatic cyc(input bit st, input bit md, input bit bv, input bit b, input bit lst);
    @(negedge clk);
    start = st; mode = md; bit_valid = bv; new_bit = b; last = lst;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input bit md, input logic [63:0] bits, input int n, input bit gaps);
    cyc(1'b1, md, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      while (gaps && ($urandom_range(2) == 0))
        cyc(1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      cyc(1'b0, 1'($urandom), 1'b1, md ? bits[i] : bits[n-1-i], i == n - 1);
    end
  endtask

  initial begin
    start = 0; mode = 0; bit_valid = 0; new_bit = 0; last = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    chk("reset_div5", 64'(div5), 1);
    chk("reset_busy5", 64'(busy5), 0);

    // MSB-first 1010 = 10 with N=5
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0); chk("msb_rem_1", 64'(rem5), 1); chk("msb_div_1", 64'(div5), 0);
    cyc(0, 0, 1, 0, 0); chk("msb_rem_2", 64'(rem5), 2); chk("msb_div_2", 64'(div5), 0);
    cyc(0, 0, 1, 1, 0); chk("msb_rem_3", 64'(rem5), 0); chk("msb_div_3", 64'(div5), 1);
    cyc(0, 0, 1, 0, 1); chk("msb_rem_4", 64'(rem5), 0);
    chk("msb_rv", 64'(rv5), 1); chk("msb_rd", 64'(rd5), 1);
    cyc(0, 0, 1, 1, 1); chk("msb_rv_clear", 64'(rv5), 0); chk("msb_rd_hold", 64'(rd5), 1);
    chk("msb_done_rem", 64'(rem5), 0);

    // LSB-first 13 sent as 1,0,1,1
    cyc(1, 1, 1, 1, 0); chk("lsb_start_discard", 64'(rem5), 0);
    cyc(0, 0, 1, 1, 0); chk("lsb_rem_1", 64'(rem5), 1);
    cyc(0, 0, 1, 0, 0); chk("lsb_rem_2", 64'(rem5), 1);
    cyc(0, 0, 1, 1, 0); chk("lsb_rem_3", 64'(rem5), 0);
    cyc(0, 0, 1, 1, 1); chk("lsb_rem_4", 64'(rem5), 3); chk("lsb_rem7_4", 64'(rem7), 6);
    chk("lsb_rv", 64'(rv5), 1); chk("lsb_rd", 64'(rd5), 0);

    // Randomized numbers in both modes with bit_valid gaps
    for (int k = 0; k < 6; k++) begin
      send_bits(k[0], {$urandom, $urandom}, 16, 1'b1);
      repeat ($urandom_range(3, 1)) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 10; k++)
      send_bits(1'($urandom), {$urandom, $urandom}, int'($urandom_range(30, 1)), 1'b1);

    // Overflow at 17 bits, cleared by next start
    send_bits(1'b0, {$urandom, $urandom}, 17, 1'b0);
    chk("ovf_cnt_sat", 64'(cnt5), 16); chk("ovf_set5", 64'(ovf5), 1); chk("ovf_set7", 64'(ovf7), 1);
    cyc(1, 0, 0, 0, 0); chk("ovf_clear", 64'(ovf5), 0); chk("ovf_cnt_clear", 64'(cnt5), 0);

    // Abort after 3 bits; start wins over the same-cycle bit
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 0, 0);
    chk("abort_pre_rem", 64'(rem5), 1);
    cyc(1, 0, 1, 1, 1);
    chk("abort_rem", 64'(rem5), 0); chk("abort_cnt", 64'(cnt5), 0); chk("abort_rv", 64'(rv5), 0);
    chk("abort_busy", 64'(busy5), 1);
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 1);
    chk("abort_new_rem5", 64'(rem5), 2); chk("abort_new_rd5", 64'(rd5), 0);
    chk("abort_new_rd7", 64'(rd7), 1); chk("abort_new_rv", 64'(rv5), 1);

    // Asynchronous reset mid-cycle during RUN
    cyc(1, 1, 0, 0, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0);
    chk("arst_pre_rem", 64'(rem5), 3);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy5), 0); chk("arst_rem", 64'(rem5), 0); chk("arst_div", 64'(div5), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) cyc(0, 0, 1, 1, 1);
    chk("post_rst_busy", 64'(busy5), 0); chk("post_rst_rem", 64'(rem5), 0);
    chk("post_rst_cnt", 64'(cnt5), 0); chk("post_rst_rv", 64'(rv5), 0);
    send_bits(1'b0, 64'd35, 6, 1'b0);
    chk("post_rst_rd5", 64'(rd5), 1); chk("post_rst_rd7", 64'(rd7), 1);

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
